// File: rtl/ram_fill_check_if.sv
// Dual-port RAM connection between the fill/check traffic generator (master)
// and the block RAM under test (slave).
interface ram_fill_check_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [ADDR_W-1:0] ram_addrb;
  logic [DATA_W-1:0] ram_doutb;

  modport master (
    output ram_wea,
    output ram_addra,
    output ram_dina,
    output ram_addrb,
    input  ram_doutb
  );

  modport slave (
    input  ram_wea,
    input  ram_addra,
    input  ram_dina,
    input  ram_addrb,
    output ram_doutb
  );
endinterface

// File: rtl/ram_fill_check.sv
// RAM fill/readback checker: writes pat(a) through port A, reads back through port B.
// Optional macro RAM_CHECKER_PATTERN_EN switches to a checkerboard-modulated pattern.
module ram_fill_check #(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5),
  parameter int                ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  ram_fill_check_if.master    ram,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int FL_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addra_q;
  logic [ADDR_W-1:0] addrb_q;
  logic [FL_W-1:0]   fl_cnt_q;
  logic              go;
  logic              last_wr;
  logic              last_rd;
  logic              last_fl;

  logic [RD_LAT-1:0] vld_p;
  logic [ADDR_W-1:0] addr_p [RD_LAT];
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mism;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = DATA_W'(a) ^ SEED;
`ifdef RAM_CHECKER_PATTERN_EN
    v = v ^ {DATA_W{a[0]}};
`endif
    return v;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  assign go      = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign last_wr = &addra_q;
  assign last_rd = &addrb_q;
  assign last_fl = (fl_cnt_q == FL_W'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)   state_d = WRITE;
      WRITE:      if (last_wr) state_d = READ;
      READ:       if (last_rd) state_d = FLUSH;
      FLUSH:      if (last_fl) state_d = DONE;
      default:                 state_d = IDLE;
    endcase
  end

  // Address counters only move inside their own phase and are re-armed to 0
  // on the transition into it, so each port holds its last address otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addra_q  <= '0;
      addrb_q  <= '0;
      fl_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) addra_q <= '0;
        WRITE: begin
          if (last_wr) addrb_q <= '0;
          else         addra_q <= addra_q + ADDR_W'(1);
        end
        READ: begin
          if (last_rd) fl_cnt_q <= '0;
          else         addrb_q  <= addrb_q + ADDR_W'(1);
        end
        FLUSH:   fl_cnt_q <= fl_cnt_q + FL_W'(1);
        default: ;
      endcase
    end
  end

  // Stage p0..p(RD_LAT-1): read-address tracking aligned with RAM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state_q == READ);
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= addrb_q;
    for (int i = 1; i < RD_LAT; i++) addr_p[i] <= addr_p[i-1];
  end

  assign cmp_vld  = vld_p[RD_LAT-1];
  assign cmp_addr = addr_p[RD_LAT-1];
  assign mism     = cmp_vld && (ram.ram_doutb != pat(cmp_addr));

  // Compare stage: a zero count means no earlier mismatch in this run
  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mism) begin
      err_count <= sat_inc(err_count);
      if (err_count == '0) first_err_addr <= cmp_addr;
    end
  end

  assign busy          = (state_q == WRITE) || (state_q == READ) || (state_q == FLUSH);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_count == '0);
  assign ram.ram_wea   = (state_q == WRITE);
  assign ram.ram_addra = addra_q;
  assign ram.ram_dina  = (state_q == WRITE) ? pat(addra_q) : '0;
  assign ram.ram_addrb = addrb_q;

endmodule

// File: tb/tb_ram_fill_check.sv
// Directed bench for ram_fill_check: three instances (default, ERR_W=2, RD_LAT=3)
// each driving its own behavioural dual-port RAM with optional read-fault injection.
module tb_ram_fill_check;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1, start2;
  int   checks   = 0;
  int   failures = 0;
  int   fm0 = 0, fm1 = 0, fm2 = 0;
  int   n, bc;

  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] err0, err2;
  logic [1:0] err1;
  logic [3:0] fea0, fea1, fea2;

  ram_fill_check_if #(.ADDR_W(4), .DATA_W(8)) rif0 ();
  ram_fill_check_if #(.ADDR_W(4), .DATA_W(8)) rif1 ();
  ram_fill_check_if #(.ADDR_W(4), .DATA_W(8)) rif2 ();

  ram_fill_check #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .SEED(8'hA5), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .ram(rif0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_err_addr(fea0));

  ram_fill_check #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .SEED(8'hA5), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start1), .ram(rif1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_err_addr(fea1));

  ram_fill_check #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .SEED(8'hA5), .ERR_W(8)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .ram(rif2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_err_addr(fea2));

  always #5 clk = ~clk;

  function automatic logic [7:0] flt(input logic [7:0] d, input logic [3:0] a, input int m);
    if (m == 1) return (a == 4'd5 || a == 4'd9) ? 8'h00 : d;
    if (m == 2) return ~d;
    return d;
  endfunction

  function automatic logic [7:0] exp_pat(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'hA5;
`ifdef RAM_CHECKER_PATTERN_EN
    if (a % 2 == 1) v = ~v;
`endif
    return v;
  endfunction

  // Behavioural RAMs: 1-cycle read for instances 0/1, 3-cycle read for instance 2
  logic [7:0] mem0 [16], mem1 [16], mem2 [16];
  logic [7:0] rd0, rd1, rd2_p0, rd2_p1, rd2_p2;
  always @(posedge clk) begin
    if (rif0.ram_wea) mem0[rif0.ram_addra] <= rif0.ram_dina;
    if (rif1.ram_wea) mem1[rif1.ram_addra] <= rif1.ram_dina;
    if (rif2.ram_wea) mem2[rif2.ram_addra] <= rif2.ram_dina;
    rd0    <= flt(mem0[rif0.ram_addrb], rif0.ram_addrb, fm0);
    rd1    <= flt(mem1[rif1.ram_addrb], rif1.ram_addrb, fm1);
    rd2_p0 <= flt(mem2[rif2.ram_addrb], rif2.ram_addrb, fm2);
    rd2_p1 <= rd2_p0;
    rd2_p2 <= rd2_p1;
  end
  assign rif0.ram_doutb = rd0;
  assign rif1.ram_doutb = rd1;
  assign rif2.ram_doutb = rd2_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int w);
    return (w == 0) ? done0 : (w == 1) ? done1 : done2;
  endfunction

  function automatic logic sel_busy(input int w);
    return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
  endfunction

  // Start pulse sampled at edge T; afterwards the n-th negedge follows edge T+n-1
  task automatic pulse(input int w);
    @(negedge clk);
    if (w == 0) start0 = 1'b1; else if (w == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // n = index of the first edge after T at which done is sampled high
  task automatic wait_done(input int w, input int n0, output int nn, output int busy_cnt);
    nn = n0;
    busy_cnt = 0;
    while (nn < 200) begin
      @(negedge clk);
      nn++;
      if (sel_busy(w)) busy_cnt++;
      if (sel_done(w)) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy0, 0);   chk("rst_done", done0, 0);   chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);     chk("rst_fea", fea0, 0);     chk("rst_wea", rif0.ram_wea, 0);
    chk("rst_addra", rif0.ram_addra, 0); chk("rst_addrb", rif0.ram_addrb, 0);
    chk("rst_dina", rif0.ram_dina, 0);
    rst_n = 1'b1;

    // Clean run with write-port sequence check
    pulse(0);
    bc = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (busy0) bc++;
      chk("wr_wea", rif0.ram_wea, 1);
      chk("wr_addra", rif0.ram_addra, k);
      chk("wr_dina", rif0.ram_dina, exp_pat(k));
    end
`ifdef RAM_CHECKER_PATTERN_EN
    chk("pat15_const", exp_pat(15), 8'h55);
`else
    chk("pat0_const", exp_pat(0), 8'hA5);
    chk("pat15_const", exp_pat(15), 8'hAA);
`endif
    begin
      int b2;
      wait_done(0, 16, n, b2);
      bc += b2;
    end
    chk("clean_latency", n, 34);
    chk("clean_busy_cycles", bc, 33);
    chk("clean_pass", pass0, 1);  chk("clean_err", err0, 0);  chk("clean_fea", fea0, 0);
    chk("clean_busy_off", busy0, 0);
    chk("hold_addra", rif0.ram_addra, 15); chk("hold_addrb", rif0.ram_addrb, 15);
    chk("done_wea", rif0.ram_wea, 0);

    // Faults at addresses 5 and 9
    fm0 = 1;
    pulse(0);
    @(negedge clk);
    chk("restart_done_clr", done0, 0);
    chk("restart_addra", rif0.ram_addra, 0);
    wait_done(0, 1, n, bc);
    chk("fault_latency", n, 34);
    chk("fault_err", err0, 2);  chk("fault_fea", fea0, 5);  chk("fault_pass", pass0, 0);

    // Start while busy is ignored; also clears previous error record
    fm0 = 0;
    pulse(0);
    repeat (10) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("ign_busy", busy0, 1);
    chk("ign_addra", rif0.ram_addra, 10);
    chk("ign_err_clr", err0, 0);
    wait_done(0, 11, n, bc);
    chk("ign_latency", n, 34);
    chk("ign_pass", pass0, 1);

    // Reset during READ after one mismatch has been recorded
    fm0 = 1;
    pulse(0);
    repeat (24) @(negedge clk);
    chk("mid_addrb", rif0.ram_addrb, 7);
    chk("mid_err", err0, 1);
    chk("mid_fea", fea0, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fm0 = 0;
    chk("mrst_busy", busy0, 0); chk("mrst_done", done0, 0); chk("mrst_wea", rif0.ram_wea, 0);
    chk("mrst_err", err0, 0);   chk("mrst_fea", fea0, 0);
    repeat (2) @(negedge clk);
    chk("mrst_idle", busy0, 0);
    pulse(0);
    wait_done(0, 0, n, bc);
    chk("mrst_latency", n, 34);
    chk("mrst_pass", pass0, 1);

    // Error counter saturation with every word corrupted
    fm1 = 2;
    pulse(1);
    wait_done(1, 0, n, bc);
    chk("sat_latency", n, 34);
    chk("sat_err", err1, 3);  chk("sat_fea", fea1, 0);  chk("sat_pass", pass1, 0);

    // Three-cycle read latency
    pulse(2);
    @(negedge clk);
    chk("l3_dina0", rif2.ram_dina, exp_pat(0));
    @(negedge clk);
`ifdef RAM_CHECKER_PATTERN_EN
    chk("l3_dina1", rif2.ram_dina, 8'h5B);
`else
    chk("l3_dina1", rif2.ram_dina, 8'hA4);
`endif
    wait_done(2, 2, n, bc);
    chk("l3_latency", n, 36);
    chk("l3_pass", pass2, 1);  chk("l3_err", err2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
